ppi_rw_control: RTL and testbench
=================================

# ppi_rw_control

Read/write control logic for the 8255A-style PPI. Samples the system-bus strobes (`CS_n`, `RD_n`, `WR_n`, `A`) and drives `control_signal`, the direction input of the data bus buffer. It also sequences reads and writes into ports A/B/C, the control word register and port C bit set/reset (BSR). It sits directly upstream of the data bus buffer and of the port blocks.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `CS_n`, `RD_n`, `WR_n`; minimum 2.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reset` in 1: 8255 RESET pin, synchronous to `clk`, active-high, already synchronized upstream.
- `CS_n`, `RD_n`, `WR_n` in 1 each: raw bus strobes, active-low, asynchronous to `clk`.
- `A` in 2: port address; 00=A, 01=B, 10=C, 11=control.
- `bus_in` in 8: internal bus value as seen inward through the data bus buffer.
- `control_signal` out 1: to data bus buffer; 1 = PPI drives PD (read), 0 = PD flows inward.
- `rd_sel` out 3: one-hot read mux select {C,B,A}.
- `wr_strobe_a`, `wr_strobe_b`, `wr_strobe_c` out 1 each: single-cycle write pulses.
- `wr_data` out 8: captured write data; valid while any strobe/`bsr_valid`/`mode_change` is high.
- `control_word` out 8: current mode control word.
- `mode_change` out 1: single-cycle pulse when `control_word` is loaded.
- `bsr_valid` out 1, `bsr_bit` out 3, `bsr_value` out 1: port C bit set/reset command.
- `bus_conflict` out 1: single-cycle pulse on illegal simultaneous RD/WR.

## Operation
- `CS_n`, `RD_n` and `WR_n` pass through `SYNC_STAGES` flops; each synchronizer resets to 1. The FSM sees only the synchronized values (`cs`, `rd`, `wr`, active-high after inversion).
- FSM states: IDLE, READ, WRITE, COMMIT.
- IDLE:
  - `cs & rd & !wr` → READ; latch `A`.
  - `cs & wr & !rd` → WRITE; latch `A`.
  - `cs & rd & wr` → stay in IDLE; pulse `bus_conflict` once per entry into that condition.
- READ:
  - `control_signal`=1.
  - `rd_sel` is decoded from latched `A`: 00→001, 01→010, 10→100.
  - `A`=11 is an illegal read: `control_signal` stays 0 and `rd_sel`=000.
  - Exit to IDLE when `!rd | !cs`.
- WRITE:
  - `wr_data` <= `bus_in` every cycle.
  - `!wr & cs` → COMMIT.
  - `!cs` while `wr` still asserted → IDLE with no commit (abort).
- COMMIT lasts one cycle, then IDLE. Its action depends on latched `A`:
  - 00/01/10: pulse the matching `wr_strobe_*`.
  - 11 with `wr_data[7]`=1: `control_word` <= `wr_data`; pulse `mode_change`.
  - 11 with `wr_data[7]`=0: pulse `bsr_valid`; `bsr_bit`=`wr_data[3:1]`, `bsr_value`=`wr_data[0]`.
- `reset`=1 has priority over all FSM activity. It forces IDLE, `control_word`=8'h9B (all ports input, mode 0), and all pulses to 0. Synchronizer contents are kept.
- Reset values (`rst_n` low): state IDLE; `control_signal` 0; `rd_sel` 000; all strobes and pulses 0; `wr_data` 8'h00; `control_word` 8'h9B; `bsr_bit` 0; `bsr_value` 0.

## Timing
- Outputs are Moore, decoded from registered state and registers.
- Pin edge → `control_signal`/`rd_sel` change: `SYNC_STAGES`+1 cycles.
- `RD_n` rising → `control_signal` returns to 0: `SYNC_STAGES`+1 cycles.
- `WR_n` rising → strobe/`mode_change`/`bsr_valid`: `SYNC_STAGES`+1 cycles, exactly 1 cycle wide.
- `wr_data` holds the last `bus_in` sampled before the synchronized `WR_n` rise, and stays stable until the next WRITE.
- A new access can be accepted in the cycle after COMMIT.
- `A` changes during an access are ignored, because `A` is latched on entry.
- `rst_n` assertion mid-access: immediate return to reset values; no strobe is issued.

## Structure
- Shared package `ppi_pkg`:
  - FSM state enum.
  - `CW_RESET` = 8'h9B.
  - Address constants `ADDR_A`, `ADDR_B`, `ADDR_C`, `ADDR_CTRL`.
  - `CW_MODE_FLAG_BIT` = 7.
- Sub-module `ppi_sync`: parameterized-depth synchronizer, reset value 1, instantiated once per strobe.

## Test plan
- After `rst_n` release: `control_word`=8'h9B, `control_signal`=0, `rd_sel`=000, all pulses 0.
- Read: `CS_n`=0, `A`=01, `RD_n` low for 6 cycles → `control_signal`=1 and `rd_sel`=010 from cycle `SYNC_STAGES`+1 while RD is held; both return to 0 `SYNC_STAGES`+1 cycles after `RD_n` rises.
- Write: `A`=10, `bus_in`=8'h5A, `WR_n` pulse → one-cycle `wr_strobe_c` with `wr_data`=8'h5A; no other strobe.
- Control: `A`=11, `bus_in`=8'h80 → `control_word`=8'h80 plus `mode_change` pulse. Then `bus_in`=8'h0B → `bsr_valid` with `bsr_bit`=5, `bsr_value`=1; `control_word` unchanged.
- Abort and conflict:
  - `CS_n` rises before `WR_n` → no strobe.
  - `RD_n` and `WR_n` low together → one `bus_conflict` pulse, `control_signal` stays 0.
- `reset` pulse after writing 8'h80 → `control_word`=8'h9B; `reset` during READ → `control_signal` 0 next cycle.

Source files
------------

// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the PPI read/write control
package ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_COMMIT = 2'd3
  } ppi_state_e;

  localparam logic [7:0] CW_RESET         = 8'h9B;
  localparam logic [1:0] ADDR_A           = 2'b00;
  localparam logic [1:0] ADDR_B           = 2'b01;
  localparam logic [1:0] ADDR_C           = 2'b10;
  localparam logic [1:0] ADDR_CTRL        = 2'b11;
  localparam int         CW_MODE_FLAG_BIT = 7;

endpackage

// File: rtl/ppi_sync.sv
// rtl/ppi_sync.sv - multi-flop synchronizer for an active-low strobe, resets to 1
module ppi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '1;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/ppi_rw_control.sv
// rtl/ppi_rw_control.sv - 8255-style bus read/write sequencer and buffer direction control
module ppi_rw_control
  import ppi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reset,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic [1:0] A,
  input  logic [7:0] bus_in,
  output logic       control_signal,
  output logic [2:0] rd_sel,
  output logic       wr_strobe_a,
  output logic       wr_strobe_b,
  output logic       wr_strobe_c,
  output logic [7:0] wr_data,
  output logic [7:0] control_word,
  output logic       mode_change,
  output logic       bsr_valid,
  output logic [2:0] bsr_bit,
  output logic       bsr_value,
  output logic       bus_conflict
);

  logic cs_n_s, rd_n_s, wr_n_s;
  logic cs, rd, wr;

  ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst_n(rst_n), .d(CS_n), .q(cs_n_s));
  ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .rst_n(rst_n), .d(RD_n), .q(rd_n_s));
  ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .rst_n(rst_n), .d(WR_n), .q(wr_n_s));

  assign cs = ~cs_n_s;
  assign rd = ~rd_n_s;
  assign wr = ~wr_n_s;

  ppi_state_e state, next_state;
  logic [1:0] addr_q;
  logic       conflict, conflict_prev;

  assign conflict = cs & rd & wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= ST_IDLE;
    else if (reset) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cs & rd & !wr)      next_state = ST_READ;
        else if (cs & wr & !rd) next_state = ST_WRITE;
      end
      ST_READ:   if (!rd || !cs) next_state = ST_IDLE;
      ST_WRITE: begin
        if (!cs)     next_state = ST_IDLE;
        else if (!wr) next_state = ST_COMMIT;
      end
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // control_word loads on the WRITE->COMMIT edge so it changes together with mode_change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= ADDR_A;
      wr_data       <= 8'h00;
      control_word  <= CW_RESET;
      conflict_prev <= 1'b0;
      bus_conflict  <= 1'b0;
    end else begin
      conflict_prev <= conflict;
      if (reset) begin
        control_word <= CW_RESET;
        bus_conflict <= 1'b0;
      end else begin
        bus_conflict <= (state == ST_IDLE) && conflict && !conflict_prev;
        if (state == ST_IDLE && next_state != ST_IDLE)
          addr_q <= A;
        if (state == ST_WRITE)
          wr_data <= bus_in;
        if (state == ST_WRITE && next_state == ST_COMMIT &&
            addr_q == ADDR_CTRL && bus_in[CW_MODE_FLAG_BIT])
          control_word <= bus_in;
      end
    end
  end

  always_comb begin
    control_signal = 1'b0;
    rd_sel         = 3'b000;
    wr_strobe_a    = 1'b0;
    wr_strobe_b    = 1'b0;
    wr_strobe_c    = 1'b0;
    mode_change    = 1'b0;
    bsr_valid      = 1'b0;
    case (state)
      ST_READ: begin
        control_signal = (addr_q != ADDR_CTRL);
        case (addr_q)
          ADDR_A:  rd_sel = 3'b001;
          ADDR_B:  rd_sel = 3'b010;
          ADDR_C:  rd_sel = 3'b100;
          default: rd_sel = 3'b000;
        endcase
      end
      ST_COMMIT: begin
        case (addr_q)
          ADDR_A:  wr_strobe_a = 1'b1;
          ADDR_B:  wr_strobe_b = 1'b1;
          ADDR_C:  wr_strobe_c = 1'b1;
          default: begin
            if (wr_data[CW_MODE_FLAG_BIT]) mode_change = 1'b1;
            else                           bsr_valid   = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign bsr_bit   = wr_data[3:1];
  assign bsr_value = wr_data[0];

endmodule

// File: tb/tb_ppi_rw_control.sv
// tb/tb_ppi_rw_control.sv - directed table-driven bench for ppi_rw_control
module tb_ppi_rw_control;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n, reset, CS_n, RD_n, WR_n;
  logic [1:0] A;
  logic [7:0] bus_in;
  logic       control_signal;
  logic [2:0] rd_sel;
  logic       wr_strobe_a, wr_strobe_b, wr_strobe_c;
  logic [7:0] wr_data, control_word;
  logic       mode_change, bsr_valid, bsr_value, bus_conflict;
  logic [2:0] bsr_bit;

  ppi_rw_control #(.SYNC_STAGES(N)) dut (
    .clk(clk), .rst_n(rst_n), .reset(reset),
    .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A), .bus_in(bus_in),
    .control_signal(control_signal), .rd_sel(rd_sel),
    .wr_strobe_a(wr_strobe_a), .wr_strobe_b(wr_strobe_b), .wr_strobe_c(wr_strobe_c),
    .wr_data(wr_data), .control_word(control_word), .mode_change(mode_change),
    .bsr_valid(bsr_valid), .bsr_bit(bsr_bit), .bsr_value(bsr_value),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  logic [2:0] strb_now;
  logic [7:0] pulses;
  assign strb_now = {wr_strobe_a, wr_strobe_b, wr_strobe_c};
  assign pulses   = {2'b00, strb_now, mode_change, bsr_valid, bus_conflict};

  typedef struct {
    logic [1:0] a;
    logic [7:0] data;
    logic [2:0] strb;
    logic       mc;
    logic       bv;
    logic [2:0] bbit;
    logic       bval;
    logic [7:0] cw;
  } wr_vec_t;

  typedef struct {
    logic [1:0] a;
    logic       cs;
    logic [2:0] sel;
  } rd_vec_t;

  wr_vec_t wv[7];
  rd_vec_t rv[4];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_write(input logic [1:0] a, input logic [7:0] d);
    A = a; bus_in = d; CS_n = 1'b0; WR_n = 1'b0;
    tick(4);
    WR_n = 1'b1;
    tick(N);
  endtask

  task automatic end_access();
    CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int cnt, cnt2;

    wv[0] = '{2'b10, 8'h5A, 3'b001, 1'b0, 1'b0, 3'd5, 1'b0, 8'h9B};
    wv[1] = '{2'b00, 8'hC3, 3'b100, 1'b0, 1'b0, 3'd1, 1'b1, 8'h9B};
    wv[2] = '{2'b01, 8'h3C, 3'b010, 1'b0, 1'b0, 3'd6, 1'b0, 8'h9B};
    wv[3] = '{2'b11, 8'h80, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h80};
    wv[4] = '{2'b11, 8'h0B, 3'b000, 1'b0, 1'b1, 3'd5, 1'b1, 8'h80};
    wv[5] = '{2'b11, 8'h0E, 3'b000, 1'b0, 1'b1, 3'd7, 1'b0, 8'h80};
    wv[6] = '{2'b11, 8'h95, 3'b000, 1'b1, 1'b0, 3'd2, 1'b1, 8'h95};

    rv[0] = '{2'b00, 1'b1, 3'b001};
    rv[1] = '{2'b01, 1'b1, 3'b010};
    rv[2] = '{2'b10, 1'b1, 3'b100};
    rv[3] = '{2'b11, 1'b0, 3'b000};

    rst_n = 1'b0; reset = 1'b0; CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    A = 2'b00; bus_in = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_control_word", control_word, 8'h9B);
    check("rst_control_signal", {7'd0, control_signal}, 8'd0);
    check("rst_rd_sel", {5'd0, rd_sel}, 8'd0);
    check("rst_pulses", pulses, 8'd0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_bsr", {4'd0, bsr_bit, bsr_value}, 8'd0);

    // Reads: output appears N+1 cycles after strobe, drops N+1 after release
    for (int i = 0; i < 4; i++) begin
      A = rv[i].a; CS_n = 1'b0; RD_n = 1'b0;
      tick(N);
      check("rd_early_cs", {7'd0, control_signal}, 8'd0);
      tick(1);
      check("rd_cs", {7'd0, control_signal}, {7'd0, rv[i].cs});
      check("rd_sel", {5'd0, rd_sel}, {5'd0, rv[i].sel});
      A = ~rv[i].a;
      tick(3);
      check("rd_sel_addr_change", {5'd0, rd_sel}, {5'd0, rv[i].sel});
      RD_n = 1'b1;
      tick(N);
      check("rd_hold_cs", {7'd0, control_signal}, {7'd0, rv[i].cs});
      tick(1);
      check("rd_release", {4'd0, control_signal, rd_sel}, 8'd0);
      end_access();
    end

    for (int i = 0; i < 7; i++) begin
      start_write(wv[i].a, wv[i].data);
      check("wr_pre_commit", pulses, 8'd0);
      tick(1);
      check("wr_strobes", {5'd0, strb_now}, {5'd0, wv[i].strb});
      check("wr_mode_change", {7'd0, mode_change}, {7'd0, wv[i].mc});
      check("wr_bsr_valid", {7'd0, bsr_valid}, {7'd0, wv[i].bv});
      check("wr_bsr_bit", {5'd0, bsr_bit}, {5'd0, wv[i].bbit});
      check("wr_bsr_value", {7'd0, bsr_value}, {7'd0, wv[i].bval});
      check("wr_data", wr_data, wv[i].data);
      check("wr_control_word", control_word, wv[i].cw);
      check("wr_conflict", {7'd0, bus_conflict}, 8'd0);
      tick(1);
      check("wr_post_commit", pulses, 8'd0);
      end_access();
    end

    // Abort: chip select drops while WR still low
    A = 2'b00; bus_in = 8'hEE; CS_n = 1'b0; WR_n = 1'b0;
    tick(4);
    CS_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(1); cnt += (pulses[7:1] != 0) ? 1 : 0; end
    WR_n = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); cnt += (pulses[7:1] != 0) ? 1 : 0; end
    check("abort_no_strobe", 8'(cnt), 8'd0);

    // Simultaneous RD and WR
    CS_n = 1'b0; RD_n = 1'b0; WR_n = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      cnt  += int'(bus_conflict);
      cnt2 += int'(control_signal);
    end
    check("conflict_pulse_count", 8'(cnt), 8'd1);
    check("conflict_cs", 8'(cnt2), 8'd0);
    end_access();

    // 8255 RESET restores the default control word
    start_write(2'b11, 8'h80);
    tick(2);
    check("pre_reset_cw", control_word, 8'h80);
    end_access();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("reset_cw", control_word, 8'h9B);
    check("reset_pulses", pulses, 8'd0);

    // RESET during a read
    A = 2'b00; CS_n = 1'b0; RD_n = 1'b0;
    tick(N + 1);
    check("read_before_reset", {7'd0, control_signal}, 8'd1);
    reset = 1'b1;
    tick(1);
    check("reset_read_cs", {7'd0, control_signal}, 8'd0);
    check("reset_read_sel", {5'd0, rd_sel}, 8'd0);
    RD_n = 1'b1; CS_n = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // rst_n asserted mid-write
    A = 2'b10; bus_in = 8'h77; CS_n = 1'b0; WR_n = 1'b0;
    tick(4);
    check("mid_write_data", wr_data, 8'h77);
    rst_n = 1'b0;
    #1;
    check("rstn_wr_data", wr_data, 8'h00);
    WR_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(1); cnt += (pulses[7:1] != 0) ? 1 : 0; end
    check("rstn_no_strobe", 8'(cnt), 8'd0);
    end_access();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
